i2c_expander_responder: RTL and testbench

I2C target that emulates the 16-bit SFP-cage GPIO expander driven by expander_top (PCA9555-compatible register map). It provides a synthesizable responder for the expander I2C buses in loopback builds and the bench, so the expander master and SFP status plumbing can be exercised without the physical part. It runs on clk_50 and oversamples open-drain SCL/SDA.

---
 rtl/i2c_expander_responder_if.sv | 9 +
 rtl/i2c_expander_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_i2c_expander_responder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_expander_responder_if.sv
// Open-drain I2C pad bundle between an I2C master (or pad model) and the expander responder.
interface i2c_expander_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_expander_responder.sv
// PCA9555-style 16-bit GPIO expander I2C target for loopback builds.
// Oversamples SCL/SDA on clk_50, filters glitches, and serves the 8-register map.
module i2c_expander_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h20,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GLITCH_CYC  = 3
) (
  input  logic                       clk_50,
  input  logic                       reset,
  i2c_expander_responder_if.slave    i2c,
  input  logic [15:0]                gpio_in,
  output logic [15:0]                gpio_out,
  output logic [15:0]                gpio_dir,
  output logic                       busy,
  output logic                       wr_strobe
);

  localparam int unsigned CNT_W = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [1:0]             line_s, filt_q, filt_p;
  logic [CNT_W-1:0]       cnt_q [2];

  // Synchronizer then per-line glitch filter; index 1 = SCL, 0 = SDA
  assign line_s = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      filt_q   <= 2'b11;
      filt_p   <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c.sda_i};
      filt_p   <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (line_s[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(GLITCH_CYC - 1)) begin
          filt_q[i] <= line_s[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_q[1];
  assign sda_f     = filt_q[0];
  assign scl_rise  =  scl_f & ~filt_p[1];
  assign scl_fall  = ~scl_f &  filt_p[1];
  // SCL must be stable high across the SDA edge, so a joint edge counts as data
  assign start_det = scl_f & filt_p[1] &  filt_p[0] & ~sda_f;
  assign stop_det  = scl_f & filt_p[1] & ~filt_p[0] &  sda_f;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d, tx_q, tx_d;
  logic [2:0] ptr_q, ptr_d, rd_sel;
  logic       rw_q, rw_d, ack_seen_q, ack_seen_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic [7:0] out0_q, out1_q, pol0_q, pol1_q, cfg0_q, cfg1_q;
  logic [7:0] out0_d, out1_d, pol0_d, pol1_d, cfg0_d, cfg1_d;
  logic [7:0] rd_byte;
  logic       rx_state, byte_done;

  // On a read ACK the byte loaded is the one after the pointer advance
  assign rd_sel = (state_q == RD_ACK) ? {ptr_q[2:1], ~ptr_q[0]} : ptr_q;

  always_comb begin
    rd_byte = 8'h00;
    case (rd_sel)
      3'd0: rd_byte = gpio_in[7:0]  ^ pol0_q;
      3'd1: rd_byte = gpio_in[15:8] ^ pol1_q;
      3'd2: rd_byte = out0_q;
      3'd3: rd_byte = out1_q;
      3'd4: rd_byte = pol0_q;
      3'd5: rd_byte = pol1_q;
      3'd6: rd_byte = cfg0_q;
      3'd7: rd_byte = cfg1_q;
      default: rd_byte = 8'h00;
    endcase
  end

  assign rx_state  = (state_q == ADDR) || (state_q == CMD) || (state_q == WR_DATA);
  assign byte_done = rx_state && scl_fall && (bit_cnt_q == 4'd8);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_seen_d  = ack_seen_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    out0_d = out0_q;  out1_d = out1_q;
    pol0_d = pol0_q;  pol1_d = pol1_q;
    cfg0_d = cfg0_q;  cfg1_d = cfg1_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      if (rx_state && scl_rise && (bit_cnt_q != 4'd8)) begin
        shreg_d   = {shreg_q[6:0], sda_f};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      case (state_q)
        ADDR: if (byte_done) begin
          if (shreg_q[7:1] == DEV_ADDR) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            rw_d     = shreg_q[0];
            state_d  = ADDR_ACK;
          end else begin
            state_d = IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!rw_q) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = CMD;
          end else begin
            tx_d      = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 4'd1;
            state_d   = RD_DATA;
          end
        end
        CMD: if (byte_done) begin
          ptr_d    = shreg_q[2:0];
          sda_oe_d = 1'b1;
          state_d  = CMD_ACK;
        end
        CMD_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = WR_DATA;
        end
        WR_DATA: if (byte_done) begin
          case (ptr_q)
            3'd2: out0_d = shreg_q;
            3'd3: out1_d = shreg_q;
            3'd4: pol0_d = shreg_q;
            3'd5: pol1_d = shreg_q;
            3'd6: cfg0_d = shreg_q;
            3'd7: cfg1_d = shreg_q;
            default: ;
          endcase
          wr_strobe_d = 1'b1;
          sda_oe_d    = 1'b1;
          state_d     = WR_ACK;
        end
        WR_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          ptr_d     = {ptr_q[2:1], ~ptr_q[0]};
          bit_cnt_d = 4'd0;
          state_d   = WR_DATA;
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d   = 1'b0;
            ack_seen_d = 1'b0;
            state_d    = RD_ACK;
          end else begin
            tx_d      = {tx_q[6:0], 1'b0};
            sda_oe_d  = ~tx_q[6];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_d = IGNORE;
            end else begin
              ptr_d      = {ptr_q[2:1], ~ptr_q[0]};
              tx_d       = rd_byte;
              ack_seen_d = 1'b1;
            end
          end else if (scl_fall && ack_seen_q) begin
            sda_oe_d   = ~tx_q[7];
            bit_cnt_d  = 4'd1;
            ack_seen_d = 1'b0;
            state_d    = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= 3'd0;
      rw_q        <= 1'b0;
      ack_seen_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      out0_q <= 8'hFF;  out1_q <= 8'hFF;
      pol0_q <= 8'h00;  pol1_q <= 8'h00;
      cfg0_q <= 8'hFF;  cfg1_q <= 8'hFF;
      gpio_out <= 16'hFFFF;
      gpio_dir <= 16'h0000;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_seen_q  <= ack_seen_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      out0_q <= out0_d;  out1_q <= out1_d;
      pol0_q <= pol0_d;  pol1_q <= pol1_d;
      cfg0_q <= cfg0_d;  cfg1_q <= cfg1_d;
      gpio_out <= {out1_q, out0_q};
      gpio_dir <= ~{cfg1_q, cfg0_q};
    end
  end

  assign i2c.sda_oe = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = wr_strobe_q;

endmodule

// File: tb/tb_i2c_expander_responder.sv
// Directed bench for i2c_expander_responder: bit-banged I2C master with open-drain SDA.
module tb_i2c_expander_responder;
  localparam int unsigned Q = 20;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [15:0] gpio_in, gpio_out, gpio_dir;
  logic        busy, wr_strobe;
  logic        m_scl, m_sda;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobe_cnt = 0;
  int          oe_cnt     = 0;

  i2c_expander_responder_if bus();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_expander_responder dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .i2c      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_dir (gpio_dir),
    .busy     (busy),
    .wr_strobe(wr_strobe)
  );

  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) if (wr_strobe) strobe_cnt++;
  always @(negedge clk_50) if (bus.sda_oe) oe_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk_50);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda = b; wq();
    m_scl = 1'b1; wq();
    if (glitch) begin
      m_sda = ~b;
      @(negedge clk_50);
      m_sda = b;
    end
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i]);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    ack = bus.sda_i;
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; wq();
      m_scl = 1'b1; wq();
      d = {d[6:0], bus.sda_i};
      wq();
      m_scl = 1'b0; wq();
    end
    send_bit(nack, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; gpio_in = 16'h1234;
    repeat (5) @(negedge clk_50);
    reset = 1'b0;
    repeat (5) @(negedge clk_50);
    n_checks++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); end
    n_checks++; if (gpio_out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_gpio_out: got %h want ffff", gpio_out); end
    n_checks++; if (gpio_dir !== 16'h0000) begin n_fail++; $display("FAIL reset_gpio_dir: got %h want 0000", gpio_dir); end
  endtask

  task automatic test_abort();
    logic a0, a1;
    int s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h40, 8'h00, a0);
    write_byte(8'h02, 8'h00, a1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    i2c_stop(); wq();
    n_checks++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL abort_acks: got %b want 00", {a0, a1}); end
    n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL abort_strobe: got %0d want 0", strobe_cnt - s0); end
    n_checks++; if (gpio_out !== 16'hFFFF) begin n_fail++; $display("FAIL abort_gpio_out: got %h want ffff", gpio_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [3:0] a;
    logic       b_mid;
    int         s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h40, 8'h00, a[3]);
    write_byte(8'h02, 8'h00, a[2]);
    write_byte(8'hA5, 8'h00, a[1]);
    write_byte(8'h3C, 8'h00, a[0]);
    b_mid = busy;
    i2c_stop(); wq();
    n_checks++; if (a !== 4'b0000) begin n_fail++; $display("FAIL write_acks: got %b want 0000", a); end
    n_checks++; if (b_mid !== 1'b1) begin n_fail++; $display("FAIL write_busy_mid: got %b want 1", b_mid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    n_checks++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL write_strobe: got %0d want 2", strobe_cnt - s0); end
    n_checks++; if (gpio_out !== 16'h3CA5) begin n_fail++; $display("FAIL write_gpio_out: got %h want 3ca5", gpio_out); end
  endtask

  task automatic test_readback();
    logic [8:0] a;
    logic [7:0] d0, d1;
    i2c_start();
    write_byte(8'h40, 8'h00, a[8]); write_byte(8'h06, 8'h00, a[7]); write_byte(8'h00, 8'h00, a[6]);
    i2c_stop();
    i2c_start();
    write_byte(8'h40, 8'h00, a[5]); write_byte(8'h04, 8'h00, a[4]); write_byte(8'hFF, 8'h00, a[3]);
    i2c_stop();
    i2c_start();
    write_byte(8'h40, 8'h00, a[2]); write_byte(8'h00, 8'h00, a[1]);
    i2c_start();
    write_byte(8'h41, 8'h00, a[0]);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    i2c_stop(); wq();
    n_checks++; if (a !== 9'h000) begin n_fail++; $display("FAIL readback_acks: got %b want 000000000", a); end
    n_checks++; if (d0 !== 8'hCB) begin n_fail++; $display("FAIL readback_reg0: got %h want cb", d0); end
    n_checks++; if (d1 !== 8'h12) begin n_fail++; $display("FAIL readback_reg1: got %h want 12", d1); end
    n_checks++; if (gpio_dir !== 16'h00FF) begin n_fail++; $display("FAIL readback_gpio_dir: got %h want 00ff", gpio_dir); end
  endtask

  task automatic test_addr_mismatch();
    logic [2:0] a;
    logic       b_mid;
    int         o0, s0;
    o0 = oe_cnt; s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h42, 8'h00, a[2]);
    write_byte(8'h02, 8'h00, a[1]);
    write_byte(8'h77, 8'h00, a[0]);
    b_mid = busy;
    i2c_stop(); wq();
    n_checks++; if (a !== 3'b111) begin n_fail++; $display("FAIL mismatch_acks: got %b want 111", a); end
    n_checks++; if (oe_cnt - o0 !== 0) begin n_fail++; $display("FAIL mismatch_sda_oe: got %0d driven cycles want 0", oe_cnt - o0); end
    n_checks++; if (b_mid !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy: got %b want 0", b_mid); end
    n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL mismatch_strobe: got %0d want 0", strobe_cnt - s0); end
    n_checks++; if (gpio_out !== 16'h3CA5) begin n_fail++; $display("FAIL mismatch_gpio_out: got %h want 3ca5", gpio_out); end
  endtask

  task automatic test_read_ptr3();
    logic [2:0] a;
    logic [7:0] d0, d1, d2;
    logic       oe_after, b_after;
    i2c_start();
    write_byte(8'h40, 8'h00, a[2]); write_byte(8'h03, 8'h00, a[1]);
    i2c_start();
    write_byte(8'h41, 8'h00, a[0]);
    read_byte(1'b0, d0);
    read_byte(1'b0, d1);
    read_byte(1'b1, d2);
    wq();
    oe_after = bus.sda_oe; b_after = busy;
    i2c_stop(); wq();
    n_checks++; if (a !== 3'b000) begin n_fail++; $display("FAIL rd3_acks: got %b want 000", a); end
    n_checks++; if ({d0, d1, d2} !== 24'h3CA53C) begin n_fail++; $display("FAIL rd3_data: got %h want 3ca53c", {d0, d1, d2}); end
    n_checks++; if (oe_after !== 1'b0) begin n_fail++; $display("FAIL rd3_release_after_nack: got %b want 0", oe_after); end
    n_checks++; if (b_after !== 1'b1) begin n_fail++; $display("FAIL rd3_busy_before_stop: got %b want 1", b_after); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd3_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    logic [2:0] a;
    logic       b_mid;
    int         s0;
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'h40, 8'h00, a[2]);
    write_byte(8'h02, 8'h00, a[1]);
    write_byte(8'h5A, 8'hC0, a[0]);
    b_mid = busy;
    i2c_stop(); wq();
    n_checks++; if (a !== 3'b000) begin n_fail++; $display("FAIL glitch_acks: got %b want 000", a); end
    n_checks++; if (b_mid !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", b_mid); end
    n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL glitch_strobe: got %0d want 1", strobe_cnt - s0); end
    n_checks++; if (gpio_out !== 16'h3C5A) begin n_fail++; $display("FAIL glitch_gpio_out: got %h want 3c5a", gpio_out); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] a;
    logic [7:0] adr;
    adr = 8'h41;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(adr[i], 1'b0);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    n_checks++; if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack_driven: got %b want 1", bus.sda_oe); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_sda_oe: got %b want 0", bus.sda_oe); end
    n_checks++; if (gpio_out !== 16'hFFFF) begin n_fail++; $display("FAIL rstmid_gpio_out: got %h want ffff", gpio_out); end
    n_checks++; if (gpio_dir !== 16'h0000) begin n_fail++; $display("FAIL rstmid_gpio_dir: got %h want 0000", gpio_dir); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    wq();
    i2c_start();
    write_byte(8'h40, 8'h00, a[2]); write_byte(8'h02, 8'h00, a[1]); write_byte(8'hA5, 8'h00, a[0]);
    i2c_stop(); wq();
    n_checks++; if (a !== 3'b000) begin n_fail++; $display("FAIL rstmid_recover_acks: got %b want 000", a); end
    n_checks++; if (gpio_out !== 16'hFFA5) begin n_fail++; $display("FAIL rstmid_recover_gpio_out: got %h want ffa5", gpio_out); end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_write();
    test_readback();
    test_addr_mismatch();
    test_read_ptr3();
    test_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
